// File: rtl/dot_product_seq_ctrl.sv
// Job sequencer for the dotProduct datapath: operand load, read sweep,
// PE pipeline drain and result store, driven by a single FSM.
module dot_product_seq_ctrl #(
  parameter int unsigned Addr_Width           = 4,
  parameter int unsigned Ram_Depth            = 1 << Addr_Width,
  parameter int unsigned Nums_Data_in_bits    = 4,
  parameter int unsigned Nums_Data            = 1 << Nums_Data_in_bits,
  parameter int unsigned Nums_Pipeline_Stages = 4,
  parameter int unsigned Pipeline_Tail        = Nums_Pipeline_Stages - 1
) (
  input  logic                  clk,
  input  logic                  Ctrl_reset_n,
  input  logic                  start,
  input  logic                  skip_load,
  input  logic                  abort,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  mem_we,
  output logic [Addr_Width-1:0] mem_waddr,
  output logic                  mem_re,
  output logic [Addr_Width-1:0] mem_raddr,
  output logic                  pe_clear,
  output logic                  pe_acc_en,
  output logic                  out_we,
  output logic [Addr_Width-1:0] out_waddr,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    STORE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int unsigned DRAIN_W = (Pipeline_Tail > 1) ? $clog2(Pipeline_Tail) : 1;
  localparam logic [Addr_Width-1:0] LAST_IDX   = Addr_Width'(Nums_Data - 1);
  localparam logic [Addr_Width-1:0] LAST_JOB   = Addr_Width'(Ram_Depth - 1);
  localparam logic [DRAIN_W-1:0]    LAST_DRAIN = DRAIN_W'(Pipeline_Tail - 1);

  state_t                          state_q;
  state_t                          state_d;
  logic [Addr_Width-1:0]           ld_cnt;
  logic [Addr_Width-1:0]           rd_cnt;
  logic [Addr_Width-1:0]           job_cnt;
  logic [DRAIN_W-1:0]              drain_cnt;
  logic [Nums_Pipeline_Stages-1:0] vpipe;

  logic load_hs;
  logic last_load;
  logic last_read;
  logic last_drain;

  assign load_hs    = (state_q == LOAD) && load_valid && !abort;
  assign last_load  = load_hs && (ld_cnt == LAST_IDX);
  assign last_read  = (state_q == COMPUTE) && (rd_cnt == LAST_IDX);
  assign last_drain = (state_q == DRAIN) && (drain_cnt == LAST_DRAIN);

  always_ff @(posedge clk or negedge Ctrl_reset_n) begin
    if (!Ctrl_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort wins over every transition, including a start seen in IDLE
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = skip_load ? COMPUTE : LOAD;
        LOAD:    if (last_load) state_d = COMPUTE;
        COMPUTE: if (last_read) state_d = DRAIN;
        DRAIN:   if (last_drain) state_d = STORE;
        STORE:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_re     = 1'b0;
    mem_raddr  = '0;
    pe_clear   = 1'b0;
    out_we     = 1'b0;
    out_waddr  = '0;
    done       = 1'b0;
    case (state_q)
      LOAD: begin
        load_ready = !abort;
        mem_we     = load_valid && !abort;
        mem_waddr  = ld_cnt;
      end
      COMPUTE: begin
        mem_re    = !abort;
        mem_raddr = rd_cnt;
        pe_clear  = (rd_cnt == '0);
      end
      STORE: begin
        out_we    = !abort;
        out_waddr = job_cnt;
      end
      DONE: done = !abort;
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign pe_acc_en = vpipe[Nums_Pipeline_Stages-1];
  assign state     = state_q;

  // vpipe tracks mem_re so pe_acc_en lines up with data leaving the PE
  always_ff @(posedge clk or negedge Ctrl_reset_n) begin
    if (!Ctrl_reset_n) begin
      ld_cnt    <= '0;
      rd_cnt    <= '0;
      job_cnt   <= '0;
      drain_cnt <= '0;
      vpipe     <= '0;
    end else if (abort) begin
      ld_cnt    <= '0;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      vpipe     <= '0;
    end else begin
      vpipe <= {vpipe[Nums_Pipeline_Stages-2:0], mem_re};
      if (load_hs) begin
        ld_cnt <= last_load ? '0 : ld_cnt + 1'b1;
      end
      if (state_q == COMPUTE) begin
        rd_cnt <= last_read ? '0 : rd_cnt + 1'b1;
      end
      if (state_q == DRAIN) begin
        drain_cnt <= last_drain ? '0 : drain_cnt + 1'b1;
      end
      if (state_q == STORE) begin
        job_cnt <= (job_cnt == LAST_JOB) ? '0 : job_cnt + 1'b1;
      end
    end
  end

endmodule
